tron_grid_engine: RTL

//  Parametrised Tron game core: per-cell occupancy map (owner codes) in dual-port RAM, 1..4 players,

---
 rtl/tron_grid_engine.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tron_grid_engine.sv
// tron_grid_engine: Tron game core. Keeps a per-cell owner map in dual-port RAM
// (game port: read + write, render port: read only), moves 1..4 players one
// cell per tick, and detects crashes, head-on collisions and the winner.
// Optional feature macro: TRON_WRAP_EN (no wall ring, moves wrap around edges).
module tron_grid_engine #(
   parameter int NUM_PLAYERS = 2,
   parameter int GRID_W      = 80,
   parameter int GRID_H      = 60,
   parameter int CELL_SHIFT  = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     tick,
   input  logic [2*NUM_PLAYERS-1:0] dir,
   input  logic [9:0]               pix_x,
   input  logic [9:0]               pix_y,
   output logic [2:0]               pix_owner,
   output logic                     pix_head,
   output logic [NUM_PLAYERS-1:0]   alive,
   output logic                     game_over,
   output logic [2:0]               winner,
   output logic                     busy
);
   localparam int XW    = $clog2(GRID_W);
   localparam int YW    = $clog2(GRID_H);
   localparam int CELLS = GRID_W * GRID_H;
   localparam int AW    = $clog2(CELLS);
   localparam int PW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam logic [2:0] WALL = 3'd7;

   typedef enum logic [2:0] {CLEAR, HEADS, READY, LATCH, CHECK, COMMIT, EVAL, OVER} stateType;

   stateType state, nextState;

   logic [2:0]    mem [CELLS];
   logic [2:0]    ramRd, pixRd;
   logic          ramWe;
   logic [AW-1:0] ramWAddr, ramRAddr, renderAddr;
   logic [2:0]    ramWData;

   logic [XW-1:0] headX [NUM_PLAYERS];
   logic [YW-1:0] headY [NUM_PLAYERS];
   logic [XW-1:0] nextX [NUM_PLAYERS];
   logic [YW-1:0] nextY [NUM_PLAYERS];
   logic [1:0]    heading [NUM_PLAYERS];
   logic [1:0]    reqHeading [NUM_PLAYERS];

   logic [NUM_PLAYERS-1:0] crash, headOn, hitVec, effCrash;
   logic [PW-1:0] pIdx, chkIdx;
   logic          chkPend, readHit, dirty, lastPlayer, gameEnds;
   logic [AW-1:0] clrAddr;
   logic [XW-1:0] clrX;
   logic [YW-1:0] clrY;
   logic          clrEdge;
   logic [2:0]    liveCount, survivor;

   logic [9:0] cellX, cellY;
   logic       inGrid, headHit, inGridQ, headQ;

   function automatic logic [AW-1:0] cellAddr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return AW'(y) * AW'(GRID_W) + AW'(x);
   endfunction

   function automatic logic [XW-1:0] startX(input int p);
      case (p)
         0:       return XW'(GRID_W / 4);
         1:       return XW'(3 * GRID_W / 4);
         default: return XW'(GRID_W / 2);
      endcase
   endfunction

   function automatic logic [YW-1:0] startY(input int p);
      case (p)
         0, 1:    return YW'(GRID_H / 2);
         2:       return YW'(GRID_H / 4);
         default: return YW'(3 * GRID_H / 4);
      endcase
   endfunction

   function automatic logic [1:0] startDir(input int p);
      case (p)
         0:       return 2'b11;
         1:       return 2'b01;
         2:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [XW-1:0] stepX(input logic [XW-1:0] x, input logic [1:0] h);
      logic [XW-1:0] r;
      r = x;
`ifdef TRON_WRAP_EN
      if (h == 2'b01)      r = (x == '0) ? XW'(GRID_W - 1) : x - XW'(1);
      else if (h == 2'b11) r = (x == XW'(GRID_W - 1)) ? '0 : x + XW'(1);
`else
      if (h == 2'b01)      r = x - XW'(1);
      else if (h == 2'b11) r = x + XW'(1);
`endif
      return r;
   endfunction

   function automatic logic [YW-1:0] stepY(input logic [YW-1:0] y, input logic [1:0] h);
      logic [YW-1:0] r;
      r = y;
`ifdef TRON_WRAP_EN
      if (h == 2'b00)      r = (y == '0) ? YW'(GRID_H - 1) : y - YW'(1);
      else if (h == 2'b10) r = (y == YW'(GRID_H - 1)) ? '0 : y + YW'(1);
`else
      if (h == 2'b00)      r = y - YW'(1);
      else if (h == 2'b10) r = y + YW'(1);
`endif
      return r;
   endfunction

   assign lastPlayer = (pIdx == PW'(NUM_PLAYERS - 1));
   assign clrEdge    = (clrX == '0) || (clrX == XW'(GRID_W - 1)) ||
                       (clrY == '0) || (clrY == YW'(GRID_H - 1));
   assign readHit    = chkPend && (ramRd != 3'd0);

   // Steering requests, head-on detection, crash merge and survivor count.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      liveCount = '0;
      survivor  = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         reqHeading[p] = (dir[2*p +: 2] == (heading[p] ^ 2'b10)) ? heading[p] : dir[2*p +: 2];
         headOn[p]     = 1'b0;
         for (int q = 0; q < NUM_PLAYERS; q++)
            if (q != p && alive[p] && alive[q] && nextX[p] == nextX[q] && nextY[p] == nextY[q])
               headOn[p] = 1'b1;
         hitVec[p] = readHit && (chkIdx == PW'(p));
         if (alive[p]) begin
            liveCount = liveCount + 3'd1;
            survivor  = 3'(p + 1);
         end
      end
      effCrash = crash | hitVec | ((state == CHECK) ? headOn : '0);
      gameEnds = (NUM_PLAYERS >= 2) ? (liveCount <= 3'd1) : (liveCount == 3'd0);
   end

   // Next-state logic and game-port RAM controls.
   always_comb begin
      nextState = state;
      ramWe     = 1'b0;
      ramWAddr  = '0;
      ramWData  = '0;
      ramRAddr  = cellAddr(nextX[pIdx], nextY[pIdx]);
      case (state)
         CLEAR: begin
            ramWe    = 1'b1;
            ramWAddr = clrAddr;
`ifdef TRON_WRAP_EN
            ramWData = 3'd0;
`else
            ramWData = clrEdge ? WALL : 3'd0;
`endif
            if (clrAddr == AW'(CELLS - 1)) nextState = HEADS;
         end
         HEADS: begin
            ramWe    = 1'b1;
            ramWAddr = cellAddr(startX(int'(pIdx)), startY(int'(pIdx)));
            ramWData = 3'(pIdx) + 3'd1;
            if (lastPlayer) nextState = READY;
         end
         READY:  if (start && tick) nextState = LATCH;
         LATCH:  nextState = CHECK;
         CHECK:  if (lastPlayer) nextState = COMMIT;
         COMMIT: begin
            if (alive[pIdx] && !effCrash[pIdx]) begin
               ramWe    = 1'b1;
               ramWAddr = cellAddr(nextX[pIdx], nextY[pIdx]);
               ramWData = 3'(pIdx) + 3'd1;
            end
            if (lastPlayer) nextState = EVAL;
         end
         EVAL:    nextState = gameEnds ? OVER : READY;
         OVER:    nextState = OVER;
         default: nextState = CLEAR;
      endcase
      // A fresh, untouched map in READY needs no second sweep while start is low.
      if (!start && state != CLEAR && state != HEADS && !(state == READY && !dirty))
         nextState = CLEAR;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state always uses non-blocking assignments.
      if (reset) state <= CLEAR;
      else       state <= nextState;
   end

   // Game datapath: sweep counters, player positions, crash flags and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pIdx      <= '0;
         chkIdx    <= '0;
         chkPend   <= 1'b0;
         crash     <= '0;
         dirty     <= 1'b0;
         clrAddr   <= '0;
         clrX      <= '0;
         clrY      <= '0;
         alive     <= '0;
         game_over <= 1'b0;
         winner    <= '0;
         busy      <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            headX[p]   <= '0;
            headY[p]   <= '0;
            nextX[p]   <= '0;
            nextY[p]   <= '0;
            heading[p] <= '0;
         end
      end else begin
         busy      <= (nextState != READY) && (nextState != OVER);
         game_over <= (nextState == OVER);
         chkPend   <= (state == CHECK) && alive[pIdx];
         chkIdx    <= pIdx;

         if (nextState != state)                                  pIdx <= '0;
         else if (state == HEADS || state == CHECK || state == COMMIT) pIdx <= pIdx + PW'(1);

         if (state == CLEAR) begin
            dirty   <= 1'b0;
            clrAddr <= clrAddr + AW'(1);
            if (clrX == XW'(GRID_W - 1)) begin
               clrX <= '0;
               clrY <= clrY + YW'(1);
            end else begin
               clrX <= clrX + XW'(1);
            end
         end
         if (nextState == CLEAR && state != CLEAR) begin
            clrAddr <= '0;
            clrX    <= '0;
            clrY    <= '0;
         end

         if (state == HEADS) begin
            headX[pIdx]   <= startX(int'(pIdx));
            headY[pIdx]   <= startY(int'(pIdx));
            heading[pIdx] <= startDir(int'(pIdx));
            if (lastPlayer) alive <= '1;
         end

         if (state == LATCH) begin
            crash <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++)
               if (alive[p]) begin
                  heading[p] <= reqHeading[p];
                  nextX[p]   <= stepX(headX[p], reqHeading[p]);
                  nextY[p]   <= stepY(headY[p], reqHeading[p]);
               end
         end

         if (state == CHECK || state == COMMIT) crash <= effCrash;

         if (state == COMMIT && alive[pIdx]) begin
            dirty <= 1'b1;
            if (effCrash[pIdx]) begin
               alive[pIdx] <= 1'b0;
            end else begin
               headX[pIdx] <= nextX[pIdx];
               headY[pIdx] <= nextY[pIdx];
            end
         end

         if (state == EVAL && gameEnds) winner <= survivor;

         if (nextState == CLEAR) begin
            alive  <= '0;
            winner <= '0;
         end
      end
   end

   // Game port of the owner map: one write and one synchronous read per cycle.
   always_ff @(posedge clk) begin
      // NOTE: the map has no reset so it maps onto block RAM; the CLEAR sweep initialises it.
      if (ramWe) mem[ramWAddr] <= ramWData;
      ramRd <= mem[ramRAddr];
   end

   // Render port: independent synchronous read of the pixel's cell.
   always_ff @(posedge clk) begin
      pixRd <= mem[renderAddr];
   end

   assign cellX      = pix_x >> CELL_SHIFT;
   assign cellY      = pix_y >> CELL_SHIFT;
   assign inGrid     = (cellX < 10'(GRID_W)) && (cellY < 10'(GRID_H));
   assign renderAddr = inGrid ? (AW'(cellY) * AW'(GRID_W) + AW'(cellX)) : '0;

   // Live-head match for the pixel's cell.
   always_comb begin
      headHit = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         if (alive[p] && cellX == 10'(headX[p]) && cellY == 10'(headY[p])) headHit = 1'b1;
   end

   // Render qualifiers, aligned with the RAM read latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inGridQ <= 1'b0;
         headQ   <= 1'b0;
      end else begin
         inGridQ <= inGrid;
         headQ   <= inGrid && headHit;
      end
   end

   assign pix_owner = inGridQ ? pixRd : 3'd0;
   assign pix_head  = headQ;

endmodule
